serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first, through a single full_subtractor bit-slice.
- A registered borrow feeds each bit's result into the next cycle.
- Sits upstream of, and drives, the full_subtractor cell: it sequences operand bits and the borrow into the cell and collects its diff/bout outputs.
- Used where area matters more than latency; completes in WIDTH cycles with a start/done handshake.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bus for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: issues operands, watches status and result
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // Subtractor side: accepts operands, returns status and result
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin through a single full_subtractor slice
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    // One-bit difference and borrow-out of x - y - bi
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow_q;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             slice_diff;
    logic             slice_bout;

    // The only arithmetic: LSBs of the operand shifters plus the carried borrow
    full_subtractor u_slice (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow_q),
        .d  (slice_diff),
        .bo (slice_bout)
    );

    // Sequencer: latch operands, walk one bit per edge, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            borrow_q <= 1'b0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        borrow_q <= bus.bin;
                        count    <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_sh   <= {slice_diff, res_sh[WIDTH-1:1]};
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= slice_bout;
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        // The final bit goes straight into the published result
                        diff_q <= {slice_diff, res_sh[WIDTH-1:1]};
                        bout_q <= slice_bout;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] ediff;
        logic       ebout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // done must never stay high for two consecutive cycles
    logic done_prev;
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_cmp++;
            if (done_prev) begin
                n_bad++;
                $display("FAIL done_double: got 1 expected 0");
            end
        end
        done_prev = bus.done;
    end

    // One full transaction with latency, busy-length and hold checks
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                         input logic [7:0] ediff, input logic ebout, input logic [7:0] prev_diff,
                         input string name);
        int n;
        int busy_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_;
        bus.bin   = ~tbin;
        check({name, "_hold"}, {24'd0, bus.diff}, {24'd0, prev_diff});
        n = 1;
        busy_cnt = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, W + 1);
        check({name, "_busycnt"}, busy_cnt, W);
        check({name, "_diff"}, {24'd0, bus.diff}, {24'd0, ediff});
        check({name, "_bout"}, {31'd0, bus.bout}, {31'd0, ebout});
        @(negedge clk);
        check({name, "_done_low"}, {31'd0, bus.done}, 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int i;
        logic [7:0] last_diff;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [7:0] ed;
        logic       eb;
        int accept_cyc [4];
        int done_cyc [4];
        logic [7:0] done_val [4];
        int na, nd;
        logic busy_prev;
        int gap;

        n_cmp = 0;
        n_bad = 0;
        done_prev = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{8'h01, 8'hFF, 1'b1, 8'h01, 1'b1};

        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.diff}, 32'd0);
        check("rst_bout", {31'd0, bus.bout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        last_diff = 8'h00;
        for (int k = 0; k < 8; k++) begin
            do_op(vecs[k].a, vecs[k].b, vecs[k].bin, vecs[k].ediff, vecs[k].ebout,
                  last_diff, $sformatf("vec%0d", k));
            last_diff = vecs[k].ediff;
        end

        // start held high: one accept per W+2 cycles, mid-RUN operand change ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h80;
        bus.b = 8'h01;
        bus.bin = 1'b0;
        na = 0;
        nd = 0;
        busy_prev = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.a = 8'h33;
                bus.b = 8'h11;
            end
            if (bus.busy && !busy_prev && na < 4) begin
                accept_cyc[na] = c;
                na++;
            end
            if (bus.done && nd < 4) begin
                done_cyc[nd] = c;
                done_val[nd] = bus.diff;
                nd++;
            end
            busy_prev = bus.busy;
        end
        bus.start = 1'b0;
        check("held_accepts", na, 4);
        check("held_dones", nd, 3);
        if (na >= 2) check("held_interval", accept_cyc[1] - accept_cyc[0], W + 2);
        if (nd >= 2) check("held_done_interval", done_cyc[1] - done_cyc[0], W + 2);
        if (nd >= 1) check("held_first_diff", {24'd0, done_val[0]}, 32'h7F);
        if (nd >= 2) check("held_second_diff", {24'd0, done_val[1]}, 32'h22);
        while (bus.busy || bus.done) @(negedge clk);
        check("held_bout", {31'd0, bus.bout}, 32'd0);

        // Reset in the middle of an operation
        do_op(8'hC3, 8'h01, 1'b0, 8'hC2, 1'b0, 8'h22, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h5A;
        bus.b = 8'h3C;
        bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_diff", {24'd0, bus.diff}, 32'd0);
        check("mid_rst_bout", {31'd0, bus.bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) gap++;
        end
        check("post_rst_quiet", gap, 0);
        do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, "post_rst");

        // Randomized triples with idle gaps
        last_diff = 8'h1E;
        for (i = 0; i < 200; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            ed   = ra - rb - {7'd0, rbin};
            eb   = ({1'b0, ra} < ({1'b0, rb} + {8'd0, rbin}));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, rbin, ed, eb, last_diff, $sformatf("rnd%0d", i));
            last_diff = ed;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
